// File: rtl/watch_set_ctrl.sv
// Watch time-setting controller.
// Walks the user through hour, minute and second edit fields with two
// pre-synchronised buttons, then strobes the edited BCD time into the watch.
//   clk, reset         : clock, asynchronous active-high reset
//   mode_btn, inc_btn  : level buttons; a rising edge is one press
//   cur_*              : current BCD time from the watch (captured on edit entry)
//   *_out              : BCD load value (the edit registers)
//   set_out            : one-cycle load strobe on commit
//   edit_field         : 0 none, 1 hr, 2 min, 3 sec
module watch_set_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       inc_btn,
   input  logic [3:0] cur_hr_msb,
   input  logic [3:0] cur_hr_lsb,
   input  logic [3:0] cur_min_msb,
   input  logic [3:0] cur_min_lsb,
   input  logic [3:0] cur_sec_msb,
   input  logic [3:0] cur_sec_lsb,
   output logic [3:0] hr_msb_out,
   output logic [3:0] hr_lsb_out,
   output logic [3:0] min_msb_out,
   output logic [3:0] min_lsb_out,
   output logic [3:0] sec_msb_out,
   output logic [3:0] sec_lsb_out,
   output logic       set_out,
   output logic [1:0] edit_field
);

   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      EDIT_HR  = 3'd1,
      EDIT_MIN = 3'd2,
      EDIT_SEC = 3'd3,
      COMMIT   = 3'd4
   } state_t;

   state_t            state;
   logic              mode_prev;
   logic              inc_prev;
   logic              mode_arm;
   logic              inc_arm;
   logic [IDLE_W-1:0] idle_cnt;
   logic              mode_press;
   logic              inc_press;

   // BCD increment with wrap; out-of-range or non-BCD contents restart at 00.
   function automatic logic [7:0] bcd_inc(input logic [3:0] msb,
                                          input logic [3:0] lsb,
                                          input logic       is_hr);
      logic bad;
      logic top;
      bad = (lsb > 4'd9) ||
            (is_hr ? ((msb > 4'd2) || ((msb == 4'd2) && (lsb > 4'd3)))
                   : (msb > 4'd5));
      top = is_hr ? ((msb == 4'd2) && (lsb == 4'd3))
                  : ((msb == 4'd5) && (lsb == 4'd9));
      if (bad || top)
         return 8'h00;
      else if (lsb == 4'd9)
         return {msb + 4'd1, 4'd0};
      else
         return {msb, lsb + 4'd1};
   endfunction

   // A button is only armed once it has been seen low after reset, so a
   // button held through reset release does not count as a press.
   assign mode_press = mode_btn & ~mode_prev & mode_arm;
   assign inc_press  = inc_btn  & ~inc_prev  & inc_arm;

   // Mode/field FSM with edit registers, idle timeout and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         mode_prev   <= 1'b0;
         inc_prev    <= 1'b0;
         mode_arm    <= 1'b0;
         inc_arm     <= 1'b0;
         idle_cnt    <= '0;
         hr_msb_out  <= 4'd0;
         hr_lsb_out  <= 4'd0;
         min_msb_out <= 4'd0;
         min_lsb_out <= 4'd0;
         sec_msb_out <= 4'd0;
         sec_lsb_out <= 4'd0;
         set_out     <= 1'b0;
         edit_field  <= 2'd0;
      end else begin
         mode_prev <= mode_btn;
         inc_prev  <= inc_btn;
         mode_arm  <= mode_arm | ~mode_btn;
         inc_arm   <= inc_arm  | ~inc_btn;
         set_out   <= 1'b0;

         case (state)
            RUN: begin
               edit_field <= 2'd0;
               if (mode_press) begin
                  hr_msb_out  <= cur_hr_msb;
                  hr_lsb_out  <= cur_hr_lsb;
                  min_msb_out <= cur_min_msb;
                  min_lsb_out <= cur_min_lsb;
                  sec_msb_out <= cur_sec_msb;
                  sec_lsb_out <= cur_sec_lsb;
                  idle_cnt    <= '0;
                  state       <= EDIT_HR;
                  edit_field  <= 2'd1;
               end
            end

            EDIT_HR, EDIT_MIN, EDIT_SEC: begin
               if (mode_press) begin
                  // Mode wins over a simultaneous inc press.
                  idle_cnt <= '0;
                  case (state)
                     EDIT_HR: begin
                        state      <= EDIT_MIN;
                        edit_field <= 2'd2;
                     end
                     EDIT_MIN: begin
                        state      <= EDIT_SEC;
                        edit_field <= 2'd3;
                     end
                     default: begin
                        state      <= COMMIT;
                        edit_field <= 2'd0;
                        set_out    <= 1'b1;
                     end
                  endcase
               end else if (inc_press) begin
                  idle_cnt <= '0;
                  case (state)
                     EDIT_HR:
                        {hr_msb_out, hr_lsb_out} <= bcd_inc(hr_msb_out, hr_lsb_out, 1'b1);
                     EDIT_MIN:
                        {min_msb_out, min_lsb_out} <= bcd_inc(min_msb_out, min_lsb_out, 1'b0);
                     default:
                        {sec_msb_out, sec_lsb_out} <= bcd_inc(sec_msb_out, sec_lsb_out, 1'b0);
                  endcase
               end else if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                  // Abandon the edit silently; edited values stay visible.
                  idle_cnt   <= '0;
                  state      <= RUN;
                  edit_field <= 2'd0;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end

            COMMIT: begin
               state      <= RUN;
               edit_field <= 2'd0;
            end

            default: begin
               state      <= RUN;
               edit_field <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Testbench for watch_set_ctrl: directed scenarios plus randomized button
// sequences, checked against a field-level model of the time-setting rules.
// Commits go through a scoreboard queue popped by a set_out monitor.
module tb_watch_set_ctrl;

   localparam int unsigned T = 8;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       mode_btn = 1'b0;
   logic       inc_btn  = 1'b0;
   logic [3:0] cur [6];
   logic [3:0] hr_msb_out, hr_lsb_out, min_msb_out, min_lsb_out, sec_msb_out, sec_lsb_out;
   logic       set_out;
   logic [1:0] edit_field;
   logic [23:0] dut_time;

   int checks = 0;
   int errors = 0;
   int unsigned edge_cnt = 0;

   // Model: field 0 = not editing, 1..3 = hr/min/sec; nibbles per field.
   int          m_field = 0;
   logic [3:0]  m_msb [3];
   logic [3:0]  m_lsb [3];
   int unsigned last_pe = 0;
   logic [23:0] exp_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   assign dut_time = {hr_msb_out, hr_lsb_out, min_msb_out, min_lsb_out, sec_msb_out, sec_lsb_out};

   watch_set_ctrl #(.TIMEOUT_CYC(T)) dut (
      .clk         (clk),
      .reset       (reset),
      .mode_btn    (mode_btn),
      .inc_btn     (inc_btn),
      .cur_hr_msb  (cur[0]),
      .cur_hr_lsb  (cur[1]),
      .cur_min_msb (cur[2]),
      .cur_min_lsb (cur[3]),
      .cur_sec_msb (cur[4]),
      .cur_sec_lsb (cur[5]),
      .hr_msb_out  (hr_msb_out),
      .hr_lsb_out  (hr_lsb_out),
      .min_msb_out (min_msb_out),
      .min_lsb_out (min_lsb_out),
      .sec_msb_out (sec_msb_out),
      .sec_lsb_out (sec_lsb_out),
      .set_out     (set_out),
      .edit_field  (edit_field)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] model_time();
      return {m_msb[0], m_lsb[0], m_msb[1], m_lsb[1], m_msb[2], m_lsb[2]};
   endfunction

   // Field increment from the numeric rules: 24 hours, 60 min/sec.
   function automatic void model_inc(input int f);
      int v;
      int lim;
      lim = (f == 0) ? 24 : 60;
      v   = m_msb[f] * 10 + m_lsb[f];
      if (m_lsb[f] > 4'd9 || v >= lim) v = 0;
      else v = (v + 1) % lim;
      m_msb[f] = 4'(v / 10);
      m_lsb[f] = 4'(v % 10);
   endfunction

   function automatic void model_reset();
      m_field = 0;
      for (int k = 0; k < 3; k++) begin
         m_msb[k] = 4'd0;
         m_lsb[k] = 4'd0;
      end
   endfunction

   // Apply one press acting at edge pe to the model.
   function automatic void model_press(input bit m, input bit i, input int unsigned pe);
      if (m_field != 0 && (pe - last_pe) > T) m_field = 0;
      last_pe = pe;
      if (m) begin
         if (m_field == 0) begin
            for (int k = 0; k < 3; k++) begin
               m_msb[k] = cur[2*k];
               m_lsb[k] = cur[2*k+1];
            end
            m_field = 1;
         end else if (m_field == 3) begin
            exp_q.push_back(model_time());
            m_field = 0;
         end else begin
            m_field++;
         end
      end else if (i && m_field != 0) begin
         model_inc(m_field - 1);
      end
   endfunction

   task automatic check_state();
      check("edit_field", 32'(edit_field), m_field);
      check("time_out", 32'(dut_time), 32'(model_time()));
   endtask

   // Starts and ends at a negedge; the press acts at the following posedge.
   task automatic press(input bit m, input bit i);
      model_press(m, i, edge_cnt + 1);
      mode_btn = m;
      inc_btn  = i;
      @(negedge clk);
      check_state();
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cur(input logic [23:0] t);
      for (int k = 0; k < 6; k++) cur[k] = t[23-4*k -: 4];
   endtask

   task automatic rand_cur();
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 7) == 0)
            cur[k] = 4'($urandom_range(0, 15));
         else if (k == 0)
            cur[k] = 4'($urandom_range(0, 2));
         else if (k == 1)
            cur[k] = (cur[0] == 4'd2) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 9));
         else if (k == 2 || k == 4)
            cur[k] = 4'($urandom_range(0, 5));
         else
            cur[k] = 4'($urandom_range(0, 9));
      end
   endtask

   // Scoreboard monitor: every set_out cycle must match a queued commit.
   always @(negedge clk) begin
      if (set_out === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL set_out_unexpected: got time %h with no commit pending at t=%0t", dut_time, $time);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            if (dut_time !== e) begin
               errors++;
               $display("FAIL commit_time: got %h expected %h at t=%0t", dut_time, e, $time);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      set_cur(24'h000000);
      model_reset();
      idle(2);
      check("reset_time", 32'(dut_time), 32'h0);
      check("reset_field", 32'(edit_field), 32'h0);
      check("reset_set", 32'(set_out), 32'h0);
      reset = 1'b0;
      idle(3);

      // Basic commit: 03:45:53, two hour increments.
      set_cur(24'h034553);
      press(1, 0);
      press(0, 1);
      press(0, 1);
      press(1, 0);
      press(1, 0);
      mode_btn = 1'b1;
      model_press(1, 0, edge_cnt + 1);
      @(negedge clk);
      check("basic_set", 32'(set_out), 32'h1);
      check("basic_time", 32'(dut_time), 32'h054553);
      check("basic_field", 32'(edit_field), 32'h0);
      mode_btn = 1'b0;
      @(negedge clk);
      check("basic_set_drop", 32'(set_out), 32'h0);

      // Wrap every field: 23:59:59 -> 00:00:00.
      set_cur(24'h235959);
      press(1, 0); press(0, 1);
      press(1, 0); press(0, 1);
      press(1, 0); press(0, 1);
      check("wrap_time", 32'(dut_time), 32'h0);
      press(1, 0);

      // Invalid hour 29 clears to 00.
      set_cur(24'h291234);
      press(1, 0);
      press(0, 1);
      check("invalid_hr", 32'({hr_msb_out, hr_lsb_out}), 32'h00);
      press(1, 0); press(1, 0); press(1, 0);

      // Simultaneous mode+inc in EDIT_HR: mode wins, hour untouched.
      set_cur(24'h171010);
      press(1, 0);
      press(1, 1);
      check("simul_field", 32'(edit_field), 32'h2);
      check("simul_hr", 32'({hr_msb_out, hr_lsb_out}), 32'h17);
      press(1, 0); press(1, 0);

      // Timeout in EDIT_MIN after T idle cycles, no strobe.
      set_cur(24'h101010);
      press(1, 0);
      press(1, 0);
      idle(6);
      check("tmo_before", 32'(edit_field), 32'h2);
      idle(1);
      check("tmo_after", 32'(edit_field), 32'h0);
      press(0, 1);

      // Press landing exactly on the timeout cycle wins; one cycle later loses.
      set_cur(24'h050000);
      press(1, 0);
      idle(6);
      press(0, 1);
      check("tmo_edge_press", 32'({hr_msb_out, hr_lsb_out}), 32'h06);
      press(1, 0);
      idle(7);
      press(0, 1);
      check("tmo_edge_late", 32'(edit_field), 32'h0);

      // Reset in EDIT_SEC with inc held through release.
      set_cur(24'h121212);
      press(1, 0); press(1, 0); press(1, 0);
      reset   = 1'b1;
      inc_btn = 1'b1;
      model_reset();
      idle(2);
      check("rst_mid_time", 32'(dut_time), 32'h0);
      check("rst_mid_field", 32'(edit_field), 32'h0);
      reset = 1'b0;
      idle(3);
      check("rst_rel_time", 32'(dut_time), 32'h0);
      check("rst_rel_field", 32'(edit_field), 32'h0);
      mode_btn = 1'b1;
      model_press(1, 0, edge_cnt + 1);
      @(negedge clk);
      mode_btn = 1'b0;
      idle(3);
      check("held_inc_hr", 32'({hr_msb_out, hr_lsb_out}), 32'h12);
      check_state();
      inc_btn = 1'b0;
      @(negedge clk);
      press(0, 1);
      check("rearm_hr", 32'({hr_msb_out, hr_lsb_out}), 32'h13);
      press(1, 0); press(1, 0); press(1, 0);

      // Randomized button sequences.
      for (int n = 0; n < 400; n++) begin
         int r;
         rand_cur();
         r = $urandom_range(0, 9);
         if (r < 4)      press(1, 0);
         else if (r < 9) press(0, 1);
         else            press(1, 1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 10));
      end

      idle(5);
      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/watch_set_ctrl.md
WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

Interface
Parameters:
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning idle cycles in any edit state before the edit is aborted (minimum 2).

Ports:
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mode_btn  input  1  level, pre-synchronised; a rising edge selects the next field.
REQ-005 SHALL have port inc_btn  input  1  level, pre-synchronised; a rising edge increments the selected field.
REQ-006 SHALL have ports cur_hr_msb, cur_hr_lsb, cur_min_msb, cur_min_lsb, cur_sec_msb, cur_sec_lsb  input  4 each  current BCD time from the watch.
REQ-007 SHALL have ports hr_msb_out, hr_lsb_out, min_msb_out, min_lsb_out, sec_msb_out, sec_lsb_out  output  4 each  BCD load value for the watch.
REQ-008 SHALL have port set_out  output  1  watch load strobe.
REQ-009 SHALL have port edit_field  output  2  display select: 0 none, 1 hr, 2 min, 3 sec.

Function
REQ-010 SHALL detect a press as btn=1 while the registered previous btn=0; each press SHALL act exactly once, in the cycle after its rising edge is sampled.
REQ-011 SHALL implement the FSM states RUN, EDIT_HR, EDIT_MIN, EDIT_SEC and COMMIT.
REQ-012 In RUN, a mode press SHALL copy all six cur_* inputs into the edit registers and move the FSM to EDIT_HR.
REQ-013 Mode presses SHALL advance EDIT_HR -> EDIT_MIN -> EDIT_SEC -> COMMIT.
REQ-014 COMMIT SHALL last exactly one cycle with set_out=1, then the FSM SHALL return to RUN.
REQ-015 set_out SHALL be 0 in every state other than COMMIT.
REQ-016 An inc press in EDIT_HR SHALL advance the hour as BCD 00..23, with 23 -> 00.
REQ-017 An inc press in EDIT_MIN or EDIT_SEC SHALL advance that field as BCD 00..59, with 59 -> 00.
REQ-018 BCD increment: if lsb=9 then lsb=0 and msb+1, else lsb+1; wraps per REQ-016/017.
REQ-019 Any edit field holding an invalid BCD value (lsb>9, hr>23, min/sec msb>5) SHALL become 00 on the next inc press.
REQ-020 An inc press SHALL modify only the currently selected field.
REQ-021 An inc press in RUN or COMMIT SHALL be ignored.
REQ-022 If mode and inc presses occur in the same cycle, mode SHALL act and inc SHALL be discarded.
REQ-023 The idle counter SHALL clear on entry to EDIT_HR and on any press, and SHALL count cycles while in an edit state.
REQ-024 When the idle counter reaches TIMEOUT_CYC-1 with no press that cycle, the FSM SHALL go to RUN with no set_out pulse.
REQ-025 The six *_out ports SHALL always drive the edit registers; in RUN they hold the last captured or edited value.
REQ-026 edit_field SHALL be 1/2/3 in EDIT_HR/EDIT_MIN/EDIT_SEC, and 0 in RUN and COMMIT.

Reset
REQ-027 On reset, the FSM SHALL be in RUN, and the edit registers, previous-button registers and idle counter SHALL be 0.
REQ-028 On reset, all *_out ports SHALL be 0, set_out SHALL be 0 and edit_field SHALL be 0.
REQ-029 Reset asserted mid-edit SHALL abandon the edit immediately, with no set_out pulse during or after reset.
REQ-030 A button held high through reset release SHALL NOT register as a press until it falls and rises again.

Verification
REQ-031 Basic commit: cur=03:45:53; press mode, then inc x2 (hr), mode, mode, mode -> exactly one set_out pulse with outputs 05:45:53; edit_field sequence 1,2,3,0.
REQ-032 Wrap: cur=23:59:59; press mode, inc (hr); mode, inc (min); mode, inc (sec); mode -> set_out with 00:00:00.
REQ-033 Invalid value: cur hr=2,9 (29); press mode, inc -> hr_out=00.
REQ-034 Simultaneous: mode and inc rising in the same cycle while in EDIT_HR -> state becomes EDIT_MIN and hour is unchanged.
REQ-035 Timeout (TIMEOUT_CYC=8): enter EDIT_MIN, then no presses for 8 cycles -> RUN, set_out never 1, edit_field=0.
REQ-036 Reset in EDIT_SEC: assert reset -> outputs 00:00:00, edit_field=0, no set_out pulse; a held inc_btn through release produces no increment.
